// File: rtl/hough_scan_ctrl.sv
// Frame sequencer for the vertical-edge Hough tracker: rasters the ROI of the
// edge bitmap into the tracker, then collects and latches the tracker's line result.
module hough_scan_ctrl #(
    parameter int IMG_WIDTH   = 1280,
    parameter int IMG_HEIGHT  = 720,
    parameter int ROI_Y_START = 360,
    parameter int ADDR_W      = 20,
    parameter int RES_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [10:0]       result_x,
    output logic [20:0]       edge_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_data,
    output logic              trk_vs,
    output logic              trk_de,
    output logic              trk_edge,
    output logic [31:0]       trk_x,
    output logic [31:0]       trk_y,
    input  logic              trk_processing,
    input  logic              trk_line_detected,
    input  logic [31:0]       trk_rho
);

    localparam int XW = $clog2(IMG_WIDTH + 1);
    localparam int YW = $clog2(IMG_HEIGHT + 1);
    localparam int TW = $clog2(RES_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(ROI_Y_START * IMG_WIDTH);
    localparam logic [XW-1:0]     X_LAST     = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_FIRST    = YW'(ROI_Y_START);
    localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_HEIGHT - 1);
    localparam logic [TW-1:0]     TMO_LAST   = TW'(RES_TIMEOUT - 1);
    localparam logic [10:0]       RES_RESET  = 11'(IMG_WIDTH / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_SCAN,
        S_DRAIN,
        S_CLOSE,
        S_WAIT_RES,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            open_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [XW-1:0]   rd_x_p0;
    logic [YW-1:0]   rd_y_p0;

    logic            res_hit;
    logic            last_px;
    logic            unused_rho_hi;

    assign res_hit       = trk_line_detected & ~trk_processing;
    assign last_px       = (rd_x_p0 == X_LAST) && (rd_y_p0 == Y_LAST);
    assign unused_rho_hi = ^trk_rho[31:11];

    // The bitmap RAM already registers its read data, so the edge bit is
    // forwarded straight from it to line up with the registered strobe.
    assign trk_edge = trk_de & mem_rd_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_OPEN;
            end
            S_OPEN: begin
                if (abort)         state_d = S_IDLE;
                else if (open_cnt) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (abort)        state_d = S_IDLE;
                else if (last_px) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = abort ? S_IDLE : S_CLOSE;
            end
            S_CLOSE: begin
                state_d = abort ? S_IDLE : S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (abort)                             state_d = S_IDLE;
                else if (res_hit || tmo_cnt == TMO_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            open_cnt     <= 1'b0;
            tmo_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            trk_vs       <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            rd_x_p0      <= '0;
            rd_y_p0      <= '0;
            trk_de       <= 1'b0;
            trk_x        <= '0;
            trk_y        <= '0;
            edge_count   <= '0;
            result_x     <= RES_RESET;
            result_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            open_cnt  <= (state_q == S_OPEN) && (state_d == S_OPEN);
            tmo_cnt   <= (state_q == S_WAIT_RES) ? tmo_cnt + 1'b1 : '0;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
            trk_vs    <= (state_d == S_OPEN) || (state_d == S_SCAN) || (state_d == S_DRAIN);
            mem_rd_en <= (state_d == S_SCAN);

            // Read stage: address and coordinates of the pixel being fetched.
            if (state_q == S_IDLE && state_d == S_OPEN) begin
                mem_addr <= ADDR_START;
                rd_x_p0  <= '0;
                rd_y_p0  <= Y_FIRST;
            end else if (state_q == S_SCAN && state_d == S_SCAN) begin
                mem_addr <= mem_addr + 1'b1;
                if (rd_x_p0 == X_LAST) begin
                    rd_x_p0 <= '0;
                    rd_y_p0 <= rd_y_p0 + 1'b1;
                end else begin
                    rd_x_p0 <= rd_x_p0 + 1'b1;
                end
            end

            // Present stage: one cycle behind the read, aligned with RAM data.
            trk_de <= mem_rd_en && (state_d != S_IDLE);
            if (mem_rd_en) begin
                trk_x <= 32'(rd_x_p0);
                trk_y <= 32'(rd_y_p0);
            end

            if (state_q == S_IDLE && state_d == S_OPEN) begin
                edge_count <= '0;
            end else if (trk_de && trk_edge) begin
                edge_count <= edge_count + 21'd1;
            end

            // Result stage: on timeout the previous line position is kept.
            if (state_q == S_WAIT_RES && state_d == S_DONE) begin
                if (res_hit) begin
                    result_x     <= trk_rho[10:0];
                    result_valid <= (edge_count != '0);
                end else begin
                    result_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hough_scan_ctrl.sv
// Scoreboard bench for hough_scan_ctrl on an 8x4 image (ROI rows 2..3), with a
// synchronous bitmap RAM model and a simple tracker model reporting the last edge x.
module tb_hough_scan_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int R  = 2;
    localparam int AW = 20;
    localparam int TO = 8;
    localparam int N  = W * (H - R);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, result_valid;
    logic [10:0]   result_x;
    logic [20:0]   edge_count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_data = 1'b0;
    logic          trk_vs, trk_de, trk_edge;
    logic [31:0]   trk_x, trk_y;
    logic          trk_processing = 1'b0;
    logic          trk_line_detected = 1'b0;
    logic [31:0]   trk_rho = 32'd0;

    hough_scan_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ROI_Y_START(R), .ADDR_W(AW), .RES_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .result_valid(result_valid), .result_x(result_x),
        .edge_count(edge_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .trk_vs(trk_vs), .trk_de(trk_de), .trk_edge(trk_edge),
        .trk_x(trk_x), .trk_y(trk_y), .trk_processing(trk_processing),
        .trk_line_detected(trk_line_detected), .trk_rho(trk_rho)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int x; int y; bit e; } pix_t;
    typedef struct { int cyc; int a; } adr_t;
    typedef struct { int cyc; int rx; bit rv; int ec; } done_t;

    pix_t  pix_q[$];
    adr_t  adr_q[$];
    done_t done_q[$];
    int    vsf_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    bit          bm[32];
    bit          stuck = 1'b0;
    logic [20:0] rho_hi = 21'd0;
    logic [10:0] trk_default = 11'd0;
    int          exp_rx = W / 2;
    bit          exp_rv = 1'b0;
    int          prev_rx;
    bit          prev_rv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc - t0);
        end
    endtask

    // Bitmap RAM: one-cycle synchronous read
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (mem_addr < 20'd32) ? bm[mem_addr[4:0]] : 1'b0;
    end

    // Tracker model: arms on vs rise, remembers the last edge x, reports on vs fall
    logic        vs_d = 1'b0;
    logic        seen = 1'b0;
    logic [10:0] last_x = 11'd0;
    always @(posedge clk) begin
        vs_d <= trk_vs;
        if (trk_vs && !vs_d) begin
            trk_processing    <= 1'b1;
            trk_line_detected <= 1'b0;
            seen              <= 1'b0;
        end else if (trk_de && trk_edge) begin
            seen   <= 1'b1;
            last_x <= trk_x[10:0];
        end
        if (!trk_vs && vs_d) begin
            trk_processing    <= 1'b0;
            trk_line_detected <= !stuck;
            trk_rho           <= {rho_hi, seen ? last_x : trk_default};
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something
    logic vs_prev_m = 1'b0;
    always @(negedge clk) begin
        int rel;
        pix_t p;
        adr_t a;
        done_t d;
        int vf;
        rel = cyc - t0;
        if (mem_rd_en === 1'b1) begin
            check("addr_pending", longint'(adr_q.size() != 0), 1);
            if (adr_q.size() != 0) begin
                a = adr_q.pop_front();
                check("mem_addr", longint'(mem_addr), a.a);
                check("addr_cycle", rel, a.cyc);
            end
        end
        if (trk_de === 1'b1) begin
            check("de_with_vs", longint'(trk_vs), 1);
            check("pix_pending", longint'(pix_q.size() != 0), 1);
            if (pix_q.size() != 0) begin
                p = pix_q.pop_front();
                check("trk_x", longint'(trk_x), p.x);
                check("trk_y", longint'(trk_y), p.y);
                check("trk_edge", longint'(trk_edge), longint'(p.e));
                check("pix_cycle", rel, p.cyc);
            end
        end
        if (done === 1'b1) begin
            check("done_pending", longint'(done_q.size() != 0), 1);
            check("busy_at_done", longint'(busy), 1);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                check("done_cycle", rel, d.cyc);
                check("result_x", longint'(result_x), d.rx);
                check("result_valid", longint'(result_valid), longint'(d.rv));
                check("edge_count", longint'(edge_count), d.ec);
            end
        end
        if (trk_vs === 1'b0 && vs_prev_m === 1'b1) begin
            check("vs_fall_pending", longint'(vsf_q.size() != 0), 1);
            if (vsf_q.size() != 0) begin
                vf = vsf_q.pop_front();
                check("vs_fall_cycle", rel, vf);
            end
        end
        vs_prev_m <= trk_vs;
    end

    task automatic flush();
        pix_q.delete();
        adr_q.delete();
        done_q.delete();
        vsf_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_rvalid"}, longint'(result_valid), 0);
        check({tag, "_rx"}, longint'(result_x), W / 2);
        check({tag, "_ecount"}, longint'(edge_count), 0);
        check({tag, "_rd_en"}, longint'(mem_rd_en), 0);
        check({tag, "_addr"}, longint'(mem_addr), 0);
        check({tag, "_vs"}, longint'(trk_vs), 0);
        check({tag, "_de"}, longint'(trk_de), 0);
        check({tag, "_edge"}, longint'(trk_edge), 0);
        check({tag, "_x"}, longint'(trk_x), 0);
        check({tag, "_y"}, longint'(trk_y), 0);
    endtask

    // Reference model: derive the whole frame's expected behaviour from the bitmap
    task automatic begin_frame(input bit stk);
        int ec;
        int lx;
        int rx;
        done_t d;
        @(posedge clk); #1;
        stuck = stk;
        ec = 0;
        lx = -1;
        for (int i = 0; i < N; i++) begin
            pix_t p;
            adr_t a;
            p.x = i % W;
            p.y = R + i / W;
            p.e = bm[p.y * W + p.x];
            p.cyc = 4 + i;
            a.a = R * W + i;
            a.cyc = 3 + i;
            pix_q.push_back(p);
            adr_q.push_back(a);
            if (p.e) begin
                ec++;
                lx = p.x;
            end
        end
        vsf_q.push_back(N + 4);
        rx = (lx >= 0) ? lx : int'(trk_default);
        prev_rx = exp_rx;
        prev_rv = exp_rv;
        if (stk) begin
            d.cyc = N + 5 + TO;
            d.rx  = exp_rx;
            d.rv  = 1'b0;
        end else begin
            d.cyc = N + 6;
            d.rx  = rx;
            d.rv  = (ec != 0);
        end
        d.ec = ec;
        exp_rx = d.rx;
        exp_rv = d.rv;
        done_q.push_back(d);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic end_frame();
        for (int k = 0; k < 60 && done_q.size() != 0; k++) @(posedge clk);
        #1;
        check("done_arrived", longint'(done_q.size()), 0);
        check("pixels_consumed", longint'(pix_q.size()), 0);
        check("reads_consumed", longint'(adr_q.size()), 0);
        flush();
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_done", longint'(busy), 0);
    endtask

    task automatic clear_bm();
        for (int i = 0; i < 32; i++) bm[i] = 1'b0;
    endtask

    task automatic random_bm();
        for (int i = 0; i < 32; i++) bm[i] = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        clear_bm();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_vals("por");

        // All-zero bitmap
        trk_default = 11'd3;
        rho_hi = 21'($urandom);
        begin_frame(1'b0);
        end_frame();

        // Edges at (3,2) and (5,3), plus noise outside the ROI
        clear_bm();
        bm[2*W+3] = 1'b1;
        bm[3*W+5] = 1'b1;
        bm[0*W+6] = 1'b1;
        bm[1*W+7] = 1'b1;
        rho_hi = 21'($urandom);
        begin_frame(1'b0);
        end_frame();

        // Edge only on the very last pixel
        clear_bm();
        bm[3*W+7] = 1'b1;
        begin_frame(1'b0);
        end_frame();

        // Abort at cycle 10
        random_bm();
        begin_frame(1'b0);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        flush();
        vsf_q.push_back(cyc - t0);
        exp_rx = prev_rx;
        exp_rv = prev_rv;
        check("abort_vs", longint'(trk_vs), 0);
        check("abort_rd_en", longint'(mem_rd_en), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_rx", longint'(result_x), exp_rx);
        check("abort_rvalid", longint'(result_valid), longint'(exp_rv));
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_vs_fall_left", longint'(vsf_q.size()), 0);
        begin_frame(1'b0);
        end_frame();

        // start together with abort in IDLE is dropped
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", longint'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("start_abort_vs", longint'(trk_vs), 0);

        // Tracker never reports; a start pulsed while busy must be ignored
        random_bm();
        begin_frame(1'b1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        end_frame();

        // Reset in cycle 8 of a scan
        random_bm();
        begin_frame(1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        flush();
        vsf_q.push_back(cyc - t0);
        exp_rx = W / 2;
        exp_rv = 1'b0;
        check_reset_vals("midrst");
        repeat (5) @(posedge clk);
        random_bm();
        begin_frame(1'b0);
        end_frame();

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            random_bm();
            trk_default = 11'($urandom_range(0, 2047));
            rho_hi = 21'($urandom);
            begin_frame($urandom_range(0, 3) == 0);
            end_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hough_scan_ctrl.md
Name: hough_scan_ctrl

Overview:
Frame sequencer for the vertical-edge Hough tracker. On a start request it scans an ROI of a 1-bit Sobel edge bitmap held in synchronous memory. For each ROI pixel it drives the tracker's frame window (vs), pixel strobe (de), edge bit and x/y coordinates. When the scan ends it closes the window, waits for the tracker's line result, latches it and reports completion with an edge count. It sits between the edge-bitmap RAM and the tracker, and is the only driver of the tracker's input interface.

Parameters:
IMG_WIDTH, 1280, pixels per row
IMG_HEIGHT, 720, rows per frame
ROI_Y_START, 360, first scanned row; rows ROI_Y_START..IMG_HEIGHT-1 are scanned
ADDR_W, 20, edge-bitmap address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT
RES_TIMEOUT, 8, cycles to wait for tracker result before giving up

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  frame scan request; sampled only in IDLE
abort  in  1  cancel the current scan; no done is produced
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, scan complete
result_valid  out  1  qualifies result_x; updated with done
result_x  out  11  latched tracker rho[10:0]
edge_count  out  21  number of edge pixels in the last completed scan
mem_rd_en  out  1  bitmap read strobe
mem_addr  out  ADDR_W  bitmap address, y*IMG_WIDTH+x
mem_rd_data  in  1  edge bit; valid 1 cycle after mem_rd_en
trk_vs  out  1  tracker frame window
trk_de  out  1  tracker pixel strobe
trk_edge  out  1  edge bit for the current pixel
trk_x  out  32  pixel x, zero-extended
trk_y  out  32  pixel y, zero-extended
trk_processing  in  1  tracker frame-active flag
trk_line_detected  in  1  tracker result flag
trk_rho  in  32  tracker result x

Behaviour:
- Reset values:
  - busy, done, result_valid, mem_rd_en, trk_vs, trk_de, trk_edge = 0.
  - mem_addr, trk_x, trk_y, edge_count = 0.
  - result_x = IMG_WIDTH/2 (640).
  - FSM = IDLE.
- Reset mid-scan returns every output to these values in the next cycle; the tracker then sees vs fall, and its result is ignored.
- All outputs are registered. N = IMG_WIDTH*(IMG_HEIGHT-ROI_Y_START). Cycle 0 is the cycle in which start is sampled high in IDLE.
- FSM states:
  - IDLE: waits for start. If start and abort are high together, abort wins and start is dropped.
  - OPEN: 2 cycles (1-2). trk_vs=1, trk_de=0, so the tracker arms frame_active before the first pixel.
  - SCAN: cycles 3..N+2. mem_rd_en=1. Raster order x=0..IMG_WIDTH-1, then y++. mem_addr starts at ROI_Y_START*IMG_WIDTH and is incremented by 1 (no multiplier).
  - Pixel pipeline: read data returns one cycle after each read. trk_de=1 in cycles 4..N+3, with trk_x/trk_y delayed one cycle to align with trk_edge=mem_rd_data. edge_count increments on each trk_de&trk_edge.
  - DRAIN: cycle N+3. The last pixel is presented; trk_vs is still 1.
  - CLOSE: cycle N+4. trk_vs=0, trk_de=0.
  - WAIT_RES: waits for trk_line_detected=1 && trk_processing=0. With a compliant tracker this occurs in cycle N+5.
    - On success: latch result_x=trk_rho[10:0]; result_valid=(edge_count!=0); go to DONE.
    - After RES_TIMEOUT cycles with no result: result_valid=0, result_x holds its old value, go to DONE.
  - DONE: done=1 for exactly one cycle (N+6 nominal), then IDLE.
- busy=1 from cycle 1 through the DONE cycle.
- edge_count is cleared on entry to OPEN and holds after done.
- abort in OPEN, SCAN, DRAIN, CLOSE or WAIT_RES:
  - Next cycle: trk_vs, trk_de and mem_rd_en = 0; state = IDLE.
  - No done pulse; result_x and result_valid are unchanged.
- start while busy is ignored; start is not queued.
- Coordinate wrap: at x=IMG_WIDTH-1, x wraps to 0 and y increments. The last pixel is (IMG_WIDTH-1, IMG_HEIGHT-1); there is no overrun read past it.
- trk_vs never falls while trk_de=1. The final pixel is always presented with trk_vs=1.

Test Plan:
- Directed test parameters: IMG_WIDTH=8, IMG_HEIGHT=4, ROI_Y_START=2 (N=16).
- All-zero bitmap; start at cycle 0 -> mem_addr runs 16..31; trk_de high cycles 4..19; trk_vs falls at cycle 20; done at cycle 22; edge_count=0; result_valid=0; result_x=tracker rho.
- Edges at (3,2) and (5,3) -> trk_de cycles present them with trk_x=3/trk_y=2 and trk_x=5/trk_y=3; edge_count=2; result_x=5; result_valid=1; done at cycle 22.
- Edge only at (7,3), the last pixel -> still sampled while trk_vs=1; result_x=7; result_valid=1.
- abort at cycle 10 -> cycle 11: trk_vs=0, mem_rd_en=0, busy=0; no done; result_x keeps previous value; a new start then completes normally in 22 cycles.
- Tracker model with trk_line_detected stuck at 0 -> done at cycle N+5+RES_TIMEOUT=29 with result_valid=0; start pulsed while busy is ignored.
- reset asserted at cycle 8 of a scan -> all outputs at reset values (result_x=4) in the next cycle; the FSM is in IDLE and accepts a new start.
